// File: rtl/relu_grad_mask.sv
// Backward-pass ReLU gradient gate: stores one forward mask bit per element and zeroes upstream gradients whose forward input was not positive.
// Optional build macro RELU_GRAD_POSZERO_EN: when defined, x = +0 also passes its gradient.
module relu_grad_mask #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          fwd_valid,
  output logic          fwd_ready,
  input  logic [15:0]   fwd_data,
  input  logic          grad_valid,
  output logic          grad_ready,
  input  logic [15:0]   grad_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_data,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [DEPTH-1:0] mask_mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             mask_bit;
  logic             push;
  logic             pop;
  logic             head_mask;

`ifdef RELU_GRAD_POSZERO_EN
  assign mask_bit = ~fwd_data[15];
`else
  assign mask_bit = ~fwd_data[15] && (fwd_data[14:0] != 15'd0);
`endif

  assign fwd_ready  = (count != CW'(DEPTH));
  assign grad_ready = (count != '0) && (!out_valid || out_ready);
  assign push       = fwd_valid && fwd_ready;
  assign pop        = grad_valid && grad_ready;
  assign head_mask  = mask_mem[rd_ptr];

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
  endfunction

  // NOTE: mask storage has no reset; count gates every read, so stale bits are never observed.
  always_ff @(posedge clk) begin
    if (push && !clear) mask_mem[wr_ptr] <= mask_bit;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // Gradients are forwarded bit-exact; no FP arithmetic touches them.
      if (pop) begin
        out_data  <= head_mask ? grad_data : 16'h0000;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_relu_grad_mask.sv
// Directed self-checking bench for relu_grad_mask: vector table for mask/gating, hand sequences for full, backpressure, wrap, reset and clear.
module tb_relu_grad_mask;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        fwd_valid;
  logic        fwd_ready;
  logic [15:0] fwd_data;
  logic        grad_valid;
  logic        grad_ready;
  logic [15:0] grad_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  count;

  int errors = 0;
  int checks = 0;

  relu_grad_mask #(.DEPTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .fwd_valid  (fwd_valid),
    .fwd_ready  (fwd_ready),
    .fwd_data   (fwd_data),
    .grad_valid (grad_valid),
    .grad_ready (grad_ready),
    .grad_data  (grad_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] g;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic mask_of(input logic [15:0] x);
`ifdef RELU_GRAD_POSZERO_EN
    return ~x[15];
`else
    return ~x[15] && (x[14:0] != 15'd0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [15:0] x);
    fwd_valid = 1'b1;
    fwd_data  = x;
    tick();
    fwd_valid = 1'b0;
  endtask

  task automatic pop_one(input logic [15:0] g);
    grad_valid = 1'b1;
    grad_data  = g;
    tick();
    grad_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic exp_q[$];

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    fwd_valid  = 1'b0;
    fwd_data   = 16'h0000;
    grad_valid = 1'b0;
    grad_data  = 16'h0000;
    out_ready  = 1'b1;

    // T1 mask rules, T6 pass-through (NaN/Inf/denormal) and sign rules.
    vecs[0]  = '{16'h3C00, 16'h4000, 16'h4000};
    vecs[1]  = '{16'hBC00, 16'h4000, 16'h0000};
`ifdef RELU_GRAD_POSZERO_EN
    vecs[2]  = '{16'h0000, 16'h4000, 16'h4000};
`else
    vecs[2]  = '{16'h0000, 16'h4000, 16'h0000};
`endif
    vecs[3]  = '{16'h7E00, 16'h4000, 16'h4000};
    vecs[4]  = '{16'h3C00, 16'h7C00, 16'h7C00};
    vecs[5]  = '{16'h3C00, 16'hFE00, 16'hFE00};
    vecs[6]  = '{16'h3C00, 16'h0001, 16'h0001};
    vecs[7]  = '{16'hBC00, 16'h7C00, 16'h0000};
    vecs[8]  = '{16'hBC00, 16'hFE00, 16'h0000};
    vecs[9]  = '{16'hBC00, 16'h0001, 16'h0000};
    vecs[10] = '{16'h8000, 16'h4000, 16'h0000};
    vecs[11] = '{16'hFE00, 16'h4000, 16'h0000};
    vecs[12] = '{16'h7C00, 16'h3555, 16'h3555};
    vecs[13] = '{16'h0001, 16'h1234, 16'h1234};

    #12;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", 32'(out_data), 32'h0);
    check("rst count", 32'(count), 32'd0);
    check("rst fwd_ready", 32'(fwd_ready), 32'd1);
    check("rst grad_ready", 32'(grad_ready), 32'd0);
    rst_n = 1'b1;
    tick();

    // Each vector pushes its mask with a gradient already waiting: the gradient must not pass in the push cycle.
    for (int i = 0; i < 14; i++) begin
      fwd_valid  = 1'b1;
      fwd_data   = vecs[i].x;
      grad_valid = 1'b1;
      grad_data  = vecs[i].g;
      #1;
      check($sformatf("v%0d grad_ready empty", i), 32'(grad_ready), 32'd0);
      tick();
      fwd_valid = 1'b0;
      #1;
      check($sformatf("v%0d grad_ready", i), 32'(grad_ready), 32'd1);
      tick();
      grad_valid = 1'b0;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].exp));
      check($sformatf("v%0d count", i), 32'(count), 32'd0);
    end
    tick();
    check("drain out_valid", 32'(out_valid), 32'd0);

    // T2 full FIFO.
    do_clear();
    fwd_valid = 1'b1;
    fwd_data  = 16'h3C00;
    repeat (16) tick();
    check("full count", 32'(count), 32'd16);
    check("full fwd_ready", 32'(fwd_ready), 32'd0);
    fwd_data = 16'hBC00;
    tick();
    fwd_valid = 1'b0;
    check("17th ignored", 32'(count), 32'd16);
    pop_one(16'h4000);
    check("full pop data", 32'(out_data), 32'h4000);
    check("full pop fwd_ready", 32'(fwd_ready), 32'd1);
    check("full pop count", 32'(count), 32'd15);

    // T3 backpressure: masks 1,0,1.
    do_clear();
    push_one(16'h3C00);
    push_one(16'hBC00);
    push_one(16'h3C00);
    out_ready = 1'b0;
    pop_one(16'h4000);
    check("bp first valid", 32'(out_valid), 32'd1);
    check("bp first data", 32'(out_data), 32'h4000);
    grad_valid = 1'b1;
    grad_data  = 16'h4400;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp%0d grad_ready", c), 32'(grad_ready), 32'd0);
      check($sformatf("bp%0d out_data", c), 32'(out_data), 32'h4000);
      check($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d count", c), 32'(count), 32'd2);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp resume 2", 32'(out_data), 32'h0000);
    grad_data = 16'h4800;
    tick();
    grad_valid = 1'b0;
    check("bp resume 3", 32'(out_data), 32'h4800);
    check("bp count", 32'(count), 32'd0);

    // T4 concurrent push/pop across pointer wrap.
    do_clear();
    exp_q.delete();
    for (int i = 0; i < 45; i++) begin
      logic [15:0] x;
      logic [15:0] g;
      logic        m;
      x = (i % 3 == 0) ? 16'hBC00 : ((i % 3 == 1) ? 16'h3C00 + 16'(i) : 16'h0000);
      g = 16'h1000 + 16'(i);
      fwd_valid = 1'b1;
      fwd_data  = x;
      if (i >= 5) begin
        grad_valid = 1'b1;
        grad_data  = g;
      end
      tick();
      if (i >= 5) begin
        m = exp_q.pop_front();
        check($sformatf("wrap out %0d", i), 32'(out_data), m ? 32'(g) : 32'h0);
      end
      exp_q.push_back(mask_of(x));
    end
    fwd_valid  = 1'b0;
    grad_valid = 1'b0;
    check("wrap count", 32'(count), 32'd5);

    // T5 async reset mid-burst.
    out_ready = 1'b0;
    pop_one(16'h4000);
    check("pre-rst out_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst count", 32'(count), 32'd0);
    check("async rst out_data", 32'(out_data), 32'h0);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();

    // T5 clear with count=7, a pending output and a simultaneous push.
    for (int i = 0; i < 8; i++) push_one(16'h3C00);
    out_ready = 1'b0;
    pop_one(16'h4000);
    check("pre-clear count", 32'(count), 32'd7);
    check("pre-clear out_valid", 32'(out_valid), 32'd1);
    clear     = 1'b1;
    fwd_valid = 1'b1;
    fwd_data  = 16'h3C00;
    tick();
    clear     = 1'b0;
    fwd_valid = 1'b0;
    out_ready = 1'b1;
    check("clear count", 32'(count), 32'd0);
    check("clear out_valid", 32'(out_valid), 32'd0);
    check("clear grad_ready", 32'(grad_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
